// File: rtl/mclk_pkg.sv
// Shared encodings for the main clock mux sequencer: source codes, FSM states
// and bit positions inside the mclkmux_cfg register.
package mclk_pkg;

  localparam logic [1:0] SRC_LOCAL = 2'd0;
  localparam logic [1:0] SRC_DTC   = 2'd1;
  localparam logic [1:0] SRC_ETH   = 2'd2;

  localparam int CFG_SRC_LSB = 0;
  localparam int CFG_SRC_MSB = 1;
  localparam int CFG_AUTO    = 2;
  localparam int CFG_REVERT  = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PRE    = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Request code 3 is not a real source and falls back to the local oscillator.
  function automatic logic [1:0] map_req(input logic [1:0] raw);
    return (raw == 2'd3) ? SRC_LOCAL : raw;
  endfunction

endpackage

// File: rtl/mclk_src_qual.sv
// Per-source status qualifier: 2-flop synchronisers on ok/locked plus a
// saturating counter of consecutive good cycles.
module mclk_src_qual
  import mclk_pkg::*;
#(
  parameter int QUAL_CYCLES = 1024,
  parameter int CNT_W       = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic ok_i,
  input  logic locked_i,
  output logic good_o,
  output logic qual_o
);

  logic [1:0]       ok_sync_q;
  logic [1:0]       lock_sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign good_o = ok_sync_q[1] & lock_sync_q[1];
  assign qual_o = (cnt_q == CNT_W'(QUAL_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (!good_o) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(QUAL_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ok_sync_q   <= '0;
      lock_sync_q <= '0;
      cnt_q       <= '0;
    end else begin
      ok_sync_q   <= {ok_sync_q[0], ok_i};
      lock_sync_q <= {lock_sync_q[0], locked_i};
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/mclk_switch_ctrl.sv
// Main clock mux sequencer: failover/revert decisions with app reset held
// around every select change. Define MCLK_SWITCH_CNT_EN to build sw_count.
module mclk_switch_ctrl
  import mclk_pkg::*;
#(
  parameter int QUAL_CYCLES = 1024,
  parameter int PRE_RST     = 16,
  parameter int POST_RST    = 256,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dtcclk_ok,
  input  logic       dtcclk_locked,
  input  logic       ethrxclk_ok,
  input  logic       ethrxclk_locked,
  input  logic [7:0] mclkmux_cfg,
  output logic [1:0] mclkmux_clksel,
  output logic       mclkmux_app_rst,
  output logic       sw_busy,
  output logic       src_fault,
  output logic [7:0] sw_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       clksel_q, clksel_d;
  logic [1:0]       target_q, target_d;
  logic             src_fault_q, src_fault_d;

  logic       good1, qual1, good2, qual2;
  logic [1:0] req;
  logic       auto_en, revert_en, cur_good, req_qual, take;
  logic [3:0] unused_cfg;

  mclk_src_qual #(.QUAL_CYCLES(QUAL_CYCLES), .CNT_W(CNT_W)) u_qual_dtc (
    .clk(clk), .rstn(rstn), .ok_i(dtcclk_ok), .locked_i(dtcclk_locked),
    .good_o(good1), .qual_o(qual1)
  );

  mclk_src_qual #(.QUAL_CYCLES(QUAL_CYCLES), .CNT_W(CNT_W)) u_qual_eth (
    .clk(clk), .rstn(rstn), .ok_i(ethrxclk_ok), .locked_i(ethrxclk_locked),
    .good_o(good2), .qual_o(qual2)
  );

  assign unused_cfg = mclkmux_cfg[7:4];
  assign req        = map_req(mclkmux_cfg[CFG_SRC_MSB:CFG_SRC_LSB]);
  assign auto_en    = mclkmux_cfg[CFG_AUTO];
  assign revert_en  = mclkmux_cfg[CFG_REVERT];

  always_comb begin
    case (clksel_q)
      SRC_DTC: cur_good = good1;
      SRC_ETH: cur_good = good2;
      default: cur_good = 1'b1;
    endcase
    case (req)
      SRC_DTC: req_qual = qual1;
      SRC_ETH: req_qual = qual2;
      default: req_qual = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    clksel_d    = clksel_q;
    target_d    = target_q;
    src_fault_d = 1'b0;
    take        = 1'b0;
    case (state_q)
      RUN: begin
        timer_d = '0;
        // Failover outranks revert, so a source that qualifies just as the
        // current one dies is only considered on a later RUN cycle.
        if (auto_en && (clksel_q != SRC_LOCAL) && !cur_good) begin
          target_d = SRC_LOCAL;
          take     = 1'b1;
        end else if ((req != clksel_q) && req_qual && (!auto_en || revert_en)) begin
          target_d = req;
          take     = 1'b1;
        end else if ((req == SRC_LOCAL) && (clksel_q != SRC_LOCAL)) begin
          target_d = SRC_LOCAL;
          take     = 1'b1;
        end
        if (take) begin
          state_d = PRE;
        end else begin
          src_fault_d = (clksel_q != req) || !cur_good;
        end
      end
      PRE: begin
        if (timer_q == CNT_W'(PRE_RST - 1)) begin
          clksel_d = target_q;
          state_d  = SETTLE;
          timer_d  = '0;
        end
      end
      SETTLE: begin
        if (timer_q == CNT_W'(POST_RST - 1)) begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      default: begin
        state_d = SETTLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SETTLE;
      timer_q     <= '0;
      clksel_q    <= SRC_LOCAL;
      target_q    <= SRC_LOCAL;
      src_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      clksel_q    <= clksel_d;
      target_q    <= target_d;
      src_fault_q <= src_fault_d;
    end
  end

  assign mclkmux_clksel  = clksel_q;
  assign mclkmux_app_rst = (state_q != RUN);
  assign sw_busy         = (state_q != RUN);
  assign src_fault       = src_fault_q;

`ifdef MCLK_SWITCH_CNT_EN
  logic [7:0] sw_count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_count_q <= '0;
    end else if ((state_q == PRE) && (state_d == SETTLE)) begin
      sw_count_q <= sw_count_q + 8'd1;
    end
  end

  assign sw_count = sw_count_q;
`else
  assign sw_count = '0;
`endif

endmodule

// File: tb/tb_mclk_switch_ctrl.sv
// Bench for mclk_switch_ctrl: event-level reference model (timestamps and
// status histories) feeding a switch-completion scoreboard.
`timescale 1ns/1ps
module tb_mclk_switch_ctrl;

  localparam int QUAL  = 1024;
  localparam int PRE   = 16;
  localparam int POST  = 256;
  localparam int CNT_W = 11;
  localparam int MAXE  = 120000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dtc_ok = 1'b0, dtc_lk = 1'b0, eth_ok = 1'b0, eth_lk = 1'b0;
  logic [7:0] cfg = 8'h00;
  logic [1:0] clksel;
  logic       app_rst, busy, fault;
  logic [7:0] count;

  always #5 clk = ~clk;

  mclk_switch_ctrl #(.QUAL_CYCLES(QUAL), .PRE_RST(PRE), .POST_RST(POST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .dtcclk_ok(dtc_ok), .dtcclk_locked(dtc_lk),
    .ethrxclk_ok(eth_ok), .ethrxclk_locked(eth_lk),
    .mclkmux_cfg(cfg),
    .mclkmux_clksel(clksel), .mclkmux_app_rst(app_rst),
    .sw_busy(busy), .src_fault(fault), .sw_count(count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef MCLK_SWITCH_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // Reference model. Edge k = k-th rising edge since reset release. A raw
  // status sampled at edge j reaches the decision logic at edge j+2; a source
  // is qualified at edge k when raw status was good on all edges k-QUAL-2..k-3.
  bit rd [0:MAXE];
  bit re [0:MAXE];
  int lbd[0:MAXE];
  int lbe[0:MAXE];

  int m_edge, m_sel, m_tgt, m_sw_edge, m_run_edge, m_cnt, m_req, m_want;
  bit m_busy, m_pend, m_fault, m_auto, m_rev, m_cur_ok, m_ok_req;

  typedef struct {
    int sel;
    int run_edge;
    int cnt;
  } sb_t;
  sb_t sb[$];

  function automatic bit good_of(input int src, input int k);
    if (k - 2 < 1) return 1'b0;
    return (src == 1) ? rd[k-2] : re[k-2];
  endfunction

  function automatic bit qual_of(input int src, input int k);
    int lb;
    if (k < 3) return 1'b0;
    lb = (src == 1) ? lbd[k-3] : lbe[k-3];
    return lb <= k - QUAL - 3;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_edge = 0; rd[0] = 1'b0; re[0] = 1'b0; lbd[0] = 0; lbe[0] = 0;
      m_busy = 1'b1; m_pend = 1'b0; m_sel = 0; m_tgt = 0; m_fault = 1'b0;
      m_cnt = 0; m_run_edge = POST; m_sw_edge = 0;
      sb.delete();
      sb.push_back('{0, POST, 0});
    end else begin
      m_edge++;
      if (m_edge >= MAXE) begin
        $display("FAIL model_bound: edge %0d beyond history %0d", m_edge, MAXE);
        $fatal(1);
      end
      rd[m_edge]  = dtc_ok & dtc_lk;
      re[m_edge]  = eth_ok & eth_lk;
      lbd[m_edge] = rd[m_edge] ? lbd[m_edge-1] : m_edge;
      lbe[m_edge] = re[m_edge] ? lbe[m_edge-1] : m_edge;
      if (m_busy) begin
        m_fault = 1'b0;
        if (m_pend && m_edge == m_sw_edge + PRE) begin
          m_sel  = m_tgt;
          m_cnt  = (m_cnt + 1) % 256;
          m_pend = 1'b0;
        end
        if (m_edge == m_run_edge) m_busy = 1'b0;
      end else begin
        m_req    = (cfg[1:0] == 2'd3) ? 0 : int'(cfg[1:0]);
        m_auto   = cfg[2];
        m_rev    = cfg[3];
        m_cur_ok = (m_sel == 0) || good_of(m_sel, m_edge);
        m_ok_req = (m_req == 0) || qual_of(m_req, m_edge);
        m_want   = m_sel;
        if (m_auto && !m_cur_ok) m_want = 0;
        else if (m_req != m_sel && m_ok_req && (!m_auto || m_rev)) m_want = m_req;
        else if (m_req == 0) m_want = 0;
        if (m_want != m_sel) begin
          m_busy = 1'b1; m_pend = 1'b1; m_tgt = m_want; m_sw_edge = m_edge;
          m_run_edge = m_edge + PRE + POST; m_fault = 1'b0;
          sb.push_back('{m_want, m_run_edge, (m_cnt + 1) % 256});
        end else begin
          m_fault = (m_sel != m_req) || !m_cur_ok;
        end
      end
    end
  end

  function automatic int pack(input int sel, input bit r, input bit b, input bit f, input int c);
    return (sel << 11) | (int'(r) << 10) | (int'(b) << 9) | (int'(f) << 8) | (c & 255);
  endfunction

  // Cycle-level comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    check("outputs", pack(int'(clksel), app_rst, busy, fault, int'(count)),
          pack(m_sel, m_busy, m_busy, m_fault, exp_cnt(m_cnt)));
  end

  // Scoreboard monitor: each completed switch (busy falling) pops one entry.
  bit   prev_busy = 1'b1;
  sb_t  got;
  always @(posedge clk) begin
    #1;
    if (prev_busy && !busy) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_switch", 1, 0);
      end else begin
        got = sb.pop_front();
        $display("switch done: edge=%0d clksel=%0d sw_count=%0d", m_edge, clksel, count);
        check("sb_clksel", int'(clksel), got.sel);
        check("sb_run_edge", m_edge, got.run_edge);
        check("sb_sw_count", int'(count), exp_cnt(got.cnt));
      end
    end
    prev_busy = busy;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    rstn = 1'b1;

    // Power-up settle, local clock only.
    cyc(250);
    check("t1_app_rst_held", int'(app_rst), 1);
    cyc(50);
    check("t1_app_rst_low", int'(app_rst), 0);
    check("t1_clksel", int'(clksel), 0);

    // Manual switch to a freshly good DTC clock.
    cfg = 8'h01; dtc_ok = 1'b1; dtc_lk = 1'b1;
    cyc(1000);
    check("t2_not_yet", int'(clksel), 0);
    cyc(52);
    check("t2_clksel", int'(clksel), 1);
    check("t2_app_rst_settle", int'(app_rst), 1);
    cyc(260);
    check("t2_app_rst_low", int'(app_rst), 0);
    check("t2_sw_count", int'(count), exp_cnt(1));

    // Lock loss with auto failover.
    cfg = 8'h05; dtc_lk = 1'b0;
    cyc(3);
    check("t3_busy", int'(busy), 1);
    cyc(17);
    check("t3_clksel", int'(clksel), 0);
    cyc(270);
    check("t3_src_fault", int'(fault), 1);

    // Revert enabled: return to DTC after requalification.
    cfg = 8'h0D; dtc_lk = 1'b1;
    cyc(1000);
    check("t4_wait_qual", int'(clksel), 0);
    cyc(80);
    check("t4_revert", int'(clksel), 1);
    cyc(260);
    cfg = 8'h05; dtc_lk = 1'b0;
    cyc(300);
    dtc_lk = 1'b1;
    cyc(1600);
    check("t4_no_revert", int'(clksel), 0);
    check("t4_fault", int'(fault), 1);

    // ETH lock flapping never qualifies.
    cfg = 8'h02; eth_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eth_lk = ~eth_lk;
      cyc(500);
    end
    check("t5_clksel", int'(clksel), 0);
    check("t5_fault", int'(fault), 1);

    // Reset in the middle of PRE.
    cfg = 8'h01;
    cyc(6);
    check("t6_in_pre", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("t6_rst_clksel", int'(clksel), 0);
    check("t6_rst_app_rst", int'(app_rst), 1);
    check("t6_rst_fault", int'(fault), 0);
    check("t6_rst_count", int'(count), 0);
    cyc(2);
    rstn = 1'b1;
    cyc(1400);
    check("t6_reswitch", int'(clksel), 1);

    // Randomised configuration and status patterns.
    for (int i = 0; i < 24; i++) begin
      cfg    = 8'($urandom_range(0, 255));
      dtc_ok = ($urandom_range(0, 9) != 0);
      dtc_lk = ($urandom_range(0, 4) != 0);
      eth_ok = ($urandom_range(0, 9) != 0);
      eth_lk = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 40));
      else cyc($urandom_range(300, 1500));
    end

    // Drain to local and confirm every queued switch was seen.
    cfg = 8'h00;
    cyc(700);
    check("end_idle", int'(busy), 0);
    check("end_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
